// File: rtl/var_dly_reg.sv
// Programmable-depth sample delay line over a 2^ADDR_W x DATA_W circular buffer; latency D accepted samples.
// Optional build macro VAR_DLY_FLUSH_EN zeroes oData on reset/delay load and keeps it zero through FILL.
module var_dly_reg #(
    parameter int DATA_W  = 12,
    parameter int ADDR_W  = 5,
    parameter int DLY_DEF = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
    input  logic [ADDR_W-1:0] iDly,
    input  logic              iDlyLoad,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic              oBusy
);

    localparam logic [ADDR_W-1:0] DLY_RST = ADDR_W'(DLY_DEF);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] dly_q, dly_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] dly_new;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // A zero delay would read the slot being written this edge, so it is treated as 1.
    assign dly_new = (iDly == '0) ? ONE : iDly;
    assign ra      = wp_q - dly_q;

    // Buffer contents are deliberately not reset; FILL gates any stale read.
    always_ff @(posedge clk) begin
        if (iValid && !rst) begin
            mem[wp_q] <= iData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            wp_q    <= '0;
            fcnt_q  <= '0;
            dly_q   <= DLY_RST;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            fcnt_q  <= fcnt_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        dly_d   = dly_q;
        wp_d    = iValid ? wp_q + ONE : wp_q;
        if (iDlyLoad) begin
            // A sample arriving with the load counts as the first fill sample of the new delay.
            dly_d   = dly_new;
            fcnt_d  = iValid ? ONE : '0;
            state_d = (iValid && dly_new == ONE) ? RUN : FILL;
        end else if (iValid && state_q == FILL) begin
            fcnt_d = fcnt_q + ONE;
            if (fcnt_q + ONE == dly_q) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        vld_d  = 1'b0;
        data_d = data_q;
        if (iDlyLoad) begin
`ifdef VAR_DLY_FLUSH_EN
            data_d = '0;
`endif
        end else if (iValid && state_q == RUN) begin
            vld_d  = 1'b1;
            data_d = mem[ra];
        end
    end

    assign oData  = data_q;
    assign oValid = vld_q;
    assign oBusy  = (state_q == FILL);

endmodule
